// File: rtl/axil_regbank_pkg.sv
// -----------------------------------------------------------------------------
// axil_regbank_pkg
// Shared definitions for the AXI4-Lite register bank:
//   - AXI response codes used on BRESP / RRESP
//   - write-channel join FSM state encoding
//   - clog2 helper used to size the register index and byte-lane offset
// -----------------------------------------------------------------------------
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_e;

    // Ceiling log2; clog2(1) = 0. Only used for elaboration-time sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axil_regbank_wr_fsm.sv
// -----------------------------------------------------------------------------
// axil_regbank_wr_fsm
// Joins the independent AW and W channels of an AXI4-Lite write. Address and
// data/strobe are latched at their own handshakes; when the second of the two
// arrives, o_commit pulses for that cycle together with the effective
// address/data/strobe (live bus value if that channel handshakes this cycle,
// latched value otherwise), so the register file updates on that same edge.
// The FSM then waits in W_RESP until the B handshake.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_awaddr/i_awvalid/o_awready   write address channel
//   i_wdata/i_wstrb/i_wvalid/o_wready write data channel
//   i_bready/o_bvalid        write response handshake (response code is
//                            produced by the parent)
//   o_commit                 one-cycle strobe: write is complete this edge
//   o_addr/o_data/o_strb     effective write address, data and strobes
// -----------------------------------------------------------------------------
module axil_regbank_wr_fsm
    import axil_regbank_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_W-1:0]     i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic                  i_bready,
    output logic                  o_bvalid,
    output logic                  o_commit,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_W-1:0]     o_data,
    output logic [DATA_W/8-1:0]   o_strb
);

    wr_state_e              r_state;
    wr_state_e              w_state_nxt;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_bvalid;
    logic                   w_awready_nxt;
    logic                   w_wready_nxt;
    logic                   w_bvalid_nxt;
    logic [ADDR_W-1:0]      r_awaddr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W/8-1:0]    r_wstrb;
    logic                   w_aw_hs;
    logic                   w_w_hs;

    assign w_aw_hs = i_awvalid && r_awready;
    assign w_w_hs  = i_wvalid && r_wready;

    // State register plus registered handshake outputs derived from next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
        end
    end

    // Address / data / strobe holding registers, loaded at their handshakes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= i_awaddr;
            end else begin
                r_awaddr <= r_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end else begin
                r_wdata <= r_wdata;
                r_wstrb <= r_wstrb;
            end
        end
    end

    // Next-state logic for the AW/W join
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_state_nxt = W_RESP;
                end else if (w_aw_hs) begin
                    w_state_nxt = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_state_nxt = W_HAVE_W;
                end else begin
                    w_state_nxt = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (w_w_hs) begin
                    w_state_nxt = W_RESP;
                end else begin
                    w_state_nxt = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (w_aw_hs) begin
                    w_state_nxt = W_RESP;
                end else begin
                    w_state_nxt = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (r_bvalid && i_bready) begin
                    w_state_nxt = W_IDLE;
                end else begin
                    w_state_nxt = W_RESP;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Output decode: next-cycle readiness/valid and the commit strobe
    always_comb begin
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = 1'b0;
        case (w_state_nxt)
            W_IDLE: begin
                w_awready_nxt = 1'b1;
                w_wready_nxt  = 1'b1;
            end
            W_HAVE_AW: w_wready_nxt  = 1'b1;
            W_HAVE_W:  w_awready_nxt = 1'b1;
            W_RESP:    w_bvalid_nxt  = 1'b1;
            default: begin
                w_awready_nxt = 1'b0;
                w_wready_nxt  = 1'b0;
                w_bvalid_nxt  = 1'b0;
            end
        endcase
        // Commit on the transition into W_RESP; the channel completing this
        // cycle still has its value on the bus, not yet in the latch.
        o_commit = (r_state != W_RESP) && (w_state_nxt == W_RESP);
        o_addr   = w_aw_hs ? i_awaddr : r_awaddr;
        o_data   = w_w_hs ? i_wdata : r_wdata;
        o_strb   = w_w_hs ? i_wstrb : r_wstrb;
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;

endmodule

// File: rtl/axil_regbank.sv
// -----------------------------------------------------------------------------
// axil_regbank
// Parametrised AXI4-Lite slave register bank. NUM_REGS data-width registers
// with byte strobes; registers flagged in RO_MASK are read-only and return the
// matching status_in slice. Indices beyond NUM_REGS answer SLVERR.
//
// Ports:
//   ACLK, ARESETN            clock, async active-low reset
//   S_AXI_AW*/W*/B*          AXI4-Lite write channels (AW/W in any order)
//   S_AXI_AR*/R*             AXI4-Lite read channels (one outstanding read)
//   reg_out                  flattened register contents, reg i at slice i
//                            (RO slices driven 0)
//   status_in                read values for RO registers, slice i
//   wr_pulse                 one-cycle strobe per register on an OKAY write
// -----------------------------------------------------------------------------
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam int IDX_CLOG = clog2(NUM_REGS);
    localparam int IDX_W    = (IDX_CLOG < 1) ? 1 : IDX_CLOG;

    logic [DW-1:0]                 r_regs [NUM_REGS];
    logic [DW-1:0]                 w_status [NUM_REGS];

    logic                          w_commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_wr_addr;
    logic [DW-1:0]                 w_wr_data;
    logic [STRB_W-1:0]             w_wr_strb;
    logic [IDX_W-1:0]              w_wr_idx;
    logic [IDX_W-1:0]              w_rd_idx;
    logic                          w_wr_hit;
    logic                          w_wr_ro;
    logic                          w_wr_ok;
    logic                          w_rd_hit;
    logic [DW-1:0]                 w_rd_data;
    logic [1:0]                    w_rd_resp;
    logic                          w_ar_hs;

    logic [1:0]                    r_bresp;
    logic [NUM_REGS-1:0]           r_wr_pulse;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [DW-1:0]                 r_rdata;
    logic [1:0]                    r_rresp;

    // Address bits outside the index field, PROT and non-RO status slices
    // carry no meaning here.
    logic                          w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR, w_wr_addr, status_in};

    axil_regbank_wr_fsm #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .DATA_W (DW)
    ) u_wr_fsm (
        .i_clk     (ACLK),
        .i_rst_n   (ARESETN),
        .i_awaddr  (S_AXI_AWADDR),
        .i_awvalid (S_AXI_AWVALID),
        .o_awready (S_AXI_AWREADY),
        .i_wdata   (S_AXI_WDATA),
        .i_wstrb   (S_AXI_WSTRB),
        .i_wvalid  (S_AXI_WVALID),
        .o_wready  (S_AXI_WREADY),
        .i_bready  (S_AXI_BREADY),
        .o_bvalid  (S_AXI_BVALID),
        .o_commit  (w_commit),
        .o_addr    (w_wr_addr),
        .o_data    (w_wr_data),
        .o_strb    (w_wr_strb)
    );

    assign w_wr_idx = w_wr_addr[ADDR_LSB +: IDX_W];
    assign w_rd_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign w_ar_hs  = S_AXI_ARVALID && r_arready;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slices
        assign w_status[gi]            = status_in[gi*DW +: DW];
        assign reg_out[gi*DW +: DW]    = RO_MASK[gi] ? {DW{1'b0}} : r_regs[gi];
    end

    // Index decode: range/RO qualification for writes, read-data mux
    always_comb begin
        w_wr_hit  = 1'b0;
        w_wr_ro   = 1'b0;
        w_rd_hit  = 1'b0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_hit  = w_wr_hit | (w_wr_idx == IDX_W'(i));
            w_wr_ro   = w_wr_ro | ((w_wr_idx == IDX_W'(i)) & RO_MASK[i]);
            w_rd_hit  = w_rd_hit | (w_rd_idx == IDX_W'(i));
            w_rd_data = w_rd_data
                      | ({DW{w_rd_idx == IDX_W'(i)}} & (RO_MASK[i] ? w_status[i] : r_regs[i]));
        end
        w_wr_ok   = w_wr_hit & ~w_wr_ro;
        w_rd_resp = w_rd_hit ? RESP_OKAY : RESP_SLVERR;
    end

    // Register array: byte-strobed update on a committed write to a writable register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (w_commit && w_wr_ok && (w_wr_idx == IDX_W'(i)) && w_wr_strb[k]) begin
                        r_regs[i][8*k +: 8] <= w_wr_data[8*k +: 8];
                    end else begin
                        r_regs[i][8*k +: 8] <= r_regs[i][8*k +: 8];
                    end
                end
            end
        end
    end

    // Write response code and per-register write strobe, set at commit
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_wr_pulse[i] <= w_commit && w_wr_ok && (w_wr_idx == IDX_W'(i));
            end
            if (w_commit) begin
                r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                r_bresp <= r_bresp;
            end
        end
    end

    // Read channel: capture at AR handshake, hold until R handshake; ARREADY = !RVALID
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
        end else begin
            // Also raises ARREADY on the first edge after reset release
            r_arready <= !r_rvalid;
        end
    end

    assign S_AXI_BRESP   = r_bresp;
    assign wr_pulse      = r_wr_pulse;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axil_regbank.sv
// -----------------------------------------------------------------------------
// tb_axil_regbank
// Directed self-checking bench for axil_regbank, configured with six
// registers (index field 3 bits, so 0x18/0x1C are out of range and address
// bit 5 aliases) and register 5 read-only.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_regbank;
    import axil_regbank_pkg::*;

    localparam int               DW = 32;
    localparam int               AW = 6;
    localparam int               NR = 6;
    localparam logic [NR-1:0]    RO = 6'b100000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [AW-1:0]        S_AXI_AWADDR = '0;
    logic [2:0]           S_AXI_AWPROT = 3'b000;
    logic                 S_AXI_AWVALID = 1'b0;
    logic                 S_AXI_AWREADY;
    logic [DW-1:0]        S_AXI_WDATA = '0;
    logic [DW/8-1:0]      S_AXI_WSTRB = '0;
    logic                 S_AXI_WVALID = 1'b0;
    logic                 S_AXI_WREADY;
    logic [1:0]           S_AXI_BRESP;
    logic                 S_AXI_BVALID;
    logic                 S_AXI_BREADY = 1'b0;
    logic [AW-1:0]        S_AXI_ARADDR = '0;
    logic [2:0]           S_AXI_ARPROT = 3'b000;
    logic                 S_AXI_ARVALID = 1'b0;
    logic                 S_AXI_ARREADY;
    logic [DW-1:0]        S_AXI_RDATA;
    logic [1:0]           S_AXI_RRESP;
    logic                 S_AXI_RVALID;
    logic                 S_AXI_RREADY = 1'b0;
    logic [NR*DW-1:0]     reg_out;
    logic [NR*DW-1:0]     status_in;
    logic [NR-1:0]        wr_pulse;

    int                   checks = 0;
    int                   errors = 0;
    int                   pulse_cnt [NR];
    logic                 bv_seen = 1'b0;
    logic                 hold_ok;

    always #5 clk = ~clk;

    assign status_in = {32'hDEADBEEF, 32'h12345678, 32'h0BADF00D,
                        32'h12121212, 32'h34343434, 32'h56565656};

    axil_regbank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR),
        .RO_MASK            (RO)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .status_in     (status_in),
        .wr_pulse      (wr_pulse)
    );

    // Count negedges on which each wr_pulse bit is high
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
        if (S_AXI_BVALID) bv_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present AW and W together; returns at the negedge after both handshakes
    task automatic write_req(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb);
        bit aw_done, w_done, aw_fire, w_fire;
        int n;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge clk);
            n++;
            if (aw_fire) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; S_AXI_WVALID  = 1'b0; end
        end
        check("wr_handshakes", {aw_done, w_done}, 2'b11);
        check("wr_bvalid_latency", S_AXI_BVALID, 1'b1);
    endtask

    task automatic write_resp(output logic [1:0] resp);
        int n;
        n = 0;
        S_AXI_BREADY = 1'b1;
        while (!S_AXI_BVALID && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_wait", S_AXI_BVALID, 1'b1);
        resp = S_AXI_BRESP;
        @(negedge clk);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, output logic [1:0] resp);
        write_req(addr, data, strb);
        write_resp(resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        bit fired;
        int n;
        fired = 1'b0; n = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        while (!fired && n < 50) begin
            fired = S_AXI_ARREADY;
            @(negedge clk);
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        check("r_latency", S_AXI_RVALID, 1'b1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge clk);
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [1:0]    rr;
        logic [1:0]    resp;
        logic [DW-1:0] wv [4];
        wv[0] = 32'h1; wv[1] = 32'h2; wv[2] = 32'h3; wv[3] = 32'h4;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
        check("rst_regout", reg_out, '0);
        check("rst_pulse", wr_pulse, 6'b000000);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Basic write/readback of regs 0..3
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(4 * i), wv[i], 4'hF, resp);
            check("basic_bresp", resp, RESP_OKAY);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(4 * i), rd, rr);
            check("basic_rdata", rd, wv[i]);
            check("basic_rresp", rr, RESP_OKAY);
        end
        for (int i = 0; i < NR; i++) begin
            check("basic_pulse_cnt", pulse_cnt[i], (i < 4) ? 1 : 0);
        end

        // Byte strobes on reg 1
        axi_write(6'h04, 32'h00000001, 4'hF, resp);
        axi_write(6'h04, 32'hAABBCCDD, 4'b0011, resp);
        check("strb_bresp", resp, RESP_OKAY);
        axi_read(6'h04, rd, rr);
        check("strb_rdata", rd, 32'h0000CCDD);
        check("strb_regout", reg_out[63:32], 32'h0000CCDD);

        // W three cycles ahead of AW
        S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        check("wfirst_wready_pre", S_AXI_WREADY, 1'b1);
        @(negedge clk);
        S_AXI_WVALID = 1'b0;
        check("wfirst_wready_drop", S_AXI_WREADY, 1'b0);
        check("wfirst_awready", S_AXI_AWREADY, 1'b1);
        check("wfirst_no_bvalid", S_AXI_BVALID, 1'b0);
        repeat (2) @(negedge clk);
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        check("wfirst_bvalid", S_AXI_BVALID, 1'b1);
        check("wfirst_pulse", wr_pulse, 6'b000100);
        write_resp(resp);
        check("wfirst_bresp", resp, RESP_OKAY);
        axi_read(6'h08, rd, rr);
        check("wfirst_rdata", rd, 32'h55);

        // BREADY held low 5 cycles with a concurrent read of reg 0
        S_AXI_BREADY = 1'b0;
        write_req(6'h0C, 32'h77, 4'hF);
        hold_ok = 1'b1;
        fork
            axi_read(6'h00, rd, rr);
            begin
                for (int c = 0; c < 5; c++) begin
                    hold_ok = hold_ok & S_AXI_BVALID & ~S_AXI_AWREADY & ~S_AXI_WREADY;
                    @(negedge clk);
                end
            end
        join
        check("bhold_stable", hold_ok, 1'b1);
        check("bhold_rdata", rd, 32'h1);
        check("bhold_rresp", rr, RESP_OKAY);
        write_resp(resp);
        check("bhold_bresp", resp, RESP_OKAY);
        check("bhold_ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);

        // Out-of-range indices 6 and 7
        axi_write(6'h18, 32'hFFFFFFFF, 4'hF, resp);
        check("oor_bresp18", resp, RESP_SLVERR);
        axi_write(6'h1C, 32'hFFFFFFFF, 4'hF, resp);
        check("oor_bresp1c", resp, RESP_SLVERR);
        axi_read(6'h18, rd, rr);
        check("oor_rdata", rd, 32'h0);
        check("oor_rresp", rr, RESP_SLVERR);
        check("oor_regout", reg_out, {32'h0, 32'h0, 32'h77, 32'h55, 32'h0000CCDD, 32'h1});

        // Address bit 5 and low byte-offset bits are ignored: 0x27 -> reg 1
        axi_write(6'h27, 32'h11112222, 4'hF, resp);
        check("alias_bresp", resp, RESP_OKAY);
        axi_read(6'h04, rd, rr);
        check("alias_rdata", rd, 32'h11112222);

        // Read-only register 5
        axi_read(6'h14, rd, rr);
        check("ro_rdata", rd, 32'hDEADBEEF);
        check("ro_rresp", rr, RESP_OKAY);
        axi_write(6'h14, 32'hCAFEF00D, 4'hF, resp);
        check("ro_bresp", resp, RESP_SLVERR);
        check("ro_regout", reg_out[191:160], 32'h0);

        // Zero strobe on writable reg 0: OKAY, no change, pulse still fires
        axi_write(6'h00, 32'hFFFFFFFF, 4'h0, resp);
        check("strb0_bresp", resp, RESP_OKAY);
        axi_read(6'h00, rd, rr);
        check("strb0_rdata", rd, 32'h1);

        check("final_regout", reg_out, {32'h0, 32'h0, 32'h77, 32'h55, 32'h11112222, 32'h1});
        check("pulse_cnt0", pulse_cnt[0], 2);
        check("pulse_cnt1", pulse_cnt[1], 4);
        check("pulse_cnt2", pulse_cnt[2], 2);
        check("pulse_cnt3", pulse_cnt[3], 2);
        check("pulse_cnt4", pulse_cnt[4], 0);
        check("pulse_cnt5", pulse_cnt[5], 0);

        // Reset while in W_HAVE_AW
        S_AXI_AWADDR = 6'h0C; S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        check("mid_have_aw", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
        bv_seen = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_async_regout", reg_out, '0);
        check("mid_async_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        repeat (3) @(negedge clk);
        check("mid_no_bvalid", bv_seen, 1'b0);
        for (int i = 0; i < 5; i++) begin
            axi_read(AW'(4 * i), rd, rr);
            check("mid_rdata_zero", rd, 32'h0);
        end
        check("mid_bvalid_after", bv_seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
